mem_req_arbiter: RTL and testbench
==================================

// Module: mem_req_arbiter
// PURPOSE
// - Shares the single unified memory port between the instruction-fetch path and the data (load/store)
//   path of the cpu. Sits between the cpu front/back ends and mem; owns one outstanding transaction.
// - Issues one registered request at a time, tracks the owner, and routes the response back to it.
// PARAMETERS
// - PADDR_WIDTH  32   physical request address width
// - LINE_WIDTH   128  data width in bits (CACHE_LINE_BYTES*8)
// - SIZE_WIDTH   2    access-size code width (access_size_t encoding)
// PORTS
// - clk_i            in   1            clock, all state on rising edge
// - rst_i            in   1            asynchronous reset, active-low
// - i_req_valid_i    in   1            fetch read request; held with i_addr_i until i_gnt_o
// - i_addr_i         in   PADDR_WIDTH  fetch address
// - i_gnt_o          out  1            1-cycle pulse: fetch request accepted
// - i_rsp_valid_o    out  1            1-cycle pulse: i_rsp_data_o valid
// - i_rsp_data_o     out  LINE_WIDTH   fetched line
// - d_req_valid_i    in   1            data request; held with fields until d_gnt_o
// - d_req_we_i       in   1            1 = write, 0 = read
// - d_addr_i         in   PADDR_WIDTH  data address
// - d_size_i         in   SIZE_WIDTH   access size
// - d_wr_data_i      in   LINE_WIDTH   store data
// - d_gnt_o          out  1            1-cycle pulse: data request accepted
// - d_rsp_valid_o    out  1            1-cycle pulse: load data valid on d_rsp_data_o
// - d_rsp_data_o     out  LINE_WIDTH   load data
// - d_wr_done_o      out  1            1-cycle pulse: store completed
// - rd_req_valid_o / wr_req_valid_o  out 1  memory read / write request pulse
// - req_is_instr_o   out  1            request belongs to fetch path
// - req_address_o    out  PADDR_WIDTH  memory address (stable until response)
// - wr_data_o        out  LINE_WIDTH   memory write data (stable until write_done_i)
// - req_access_size_o out SIZE_WIDTH   memory access size
// - mem_data_valid_i in   1            memory read response valid
// - mem_data_i       in   LINE_WIDTH   memory read data
// - write_done_i     in   1            memory write completion
// - err_o            out  1            sticky protocol error flag
// BEHAVIOUR
// - Reset (rst_i=0, async): state IDLE, all outputs 0 incl. address/data/size, err_o=0, owner cleared.
// - FSM: IDLE -> RD_WAIT (read issued) | WR_WAIT (write issued); RD_WAIT --mem_data_valid_i--> IDLE;
//   WR_WAIT --write_done_i--> IDLE. Only IDLE arbitrates; requests during WAIT stay pending.
// - Issue: request seen in IDLE at edge N -> gnt pulse and rd/wr_req_valid_o pulse at cycle N+1;
//   req_address_o/req_is_instr_o/size/wr_data_o registered at N+1 and held until return to IDLE.
// - Fetch always: read, req_is_instr_o=1, size = word code (2'b10). Data: req_is_instr_o=0.
// - Response: mem_data_valid_i at cycle M -> owner's rsp_valid_o + data registered at M+1, FSM IDLE at
//   M+1; next grant earliest M+2. write_done_i at M -> d_wr_done_o at M+1. Min round trip: 2 + mem lat.
// - Routing uses the internal owner bit, not memory-side tags.
// - Arbitration (default): fixed priority, data wins when both valid in same IDLE cycle.
// - Errors (set err_o, sticky until reset): mem_data_valid_i outside RD_WAIT; write_done_i outside
//   WR_WAIT; both mem_data_valid_i and write_done_i same cycle. Stray responses are dropped, FSM unchanged.
// - Requester dropping valid before gnt: allowed; request withdrawn, nothing issued.
// - Reset mid-transaction: in-flight response is lost; a later stray response flags err_o.
// CONFIGURATION
// - MEM_ARB_RR_EN defined: round-robin; on simultaneous requests the path NOT granted last wins
//   (last-grant bit reset to data, so first tie goes to fetch). Single requester always granted.
// - MEM_ARB_RR_EN undefined: fixed data priority as above; fetch may starve under back-to-back data.
// TESTING
// - Fetch only, addr 0x1000, mem lat 3 -> rd_req pulse, req_is_instr_o=1, i_rsp_valid_o 1 cycle, data match.
// - Store d_addr 0x0040 data 0xDEADBEEF, write_done after 2 -> wr_req pulse, d_wr_done_o 1 cycle, no i_rsp.
// - Both valid same cycle, fixed prio -> d_gnt_o first, i_gnt_o after d_rsp_valid_o; RR -> i first, then d.
// - mem_data_valid_i pulsed in IDLE -> err_o=1 sticky, no rsp pulses; rst_i=0 clears err_o.
// - rst_i low during RD_WAIT -> all outputs 0 immediately; next fetch issues normally from IDLE.
// - 10 back-to-back data loads with fetch pending, RR on -> grants alternate d,i,d,i; addresses held stable.

Source files
------------

// File: rtl/mem_req_arbiter_if.sv
// Bus bundle between the cpu fetch/data paths, the memory port and mem_req_arbiter.
// Ports (all signals, named from the arbiter's point of view):
//   fetch  : i_req_valid_i, i_addr_i -> i_gnt_o, i_rsp_valid_o, i_rsp_data_o
//   data   : d_req_valid_i, d_req_we_i, d_addr_i, d_size_i, d_wr_data_i
//            -> d_gnt_o, d_rsp_valid_o, d_rsp_data_o, d_wr_done_o
//   memory : rd_req_valid_o, wr_req_valid_o, req_is_instr_o, req_address_o, wr_data_o,
//            req_access_size_o <- mem_data_valid_i, mem_data_i, write_done_i
//   status : err_o
// Modports: slave = the arbiter, master = the environment driving requests and responses.
interface mem_req_arbiter_if #(
    parameter int unsigned PADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH  = 128,
    parameter int unsigned SIZE_WIDTH  = 2
);
    logic                   i_req_valid_i;
    logic [PADDR_WIDTH-1:0] i_addr_i;
    logic                   i_gnt_o;
    logic                   i_rsp_valid_o;
    logic [LINE_WIDTH-1:0]  i_rsp_data_o;

    logic                   d_req_valid_i;
    logic                   d_req_we_i;
    logic [PADDR_WIDTH-1:0] d_addr_i;
    logic [SIZE_WIDTH-1:0]  d_size_i;
    logic [LINE_WIDTH-1:0]  d_wr_data_i;
    logic                   d_gnt_o;
    logic                   d_rsp_valid_o;
    logic [LINE_WIDTH-1:0]  d_rsp_data_o;
    logic                   d_wr_done_o;

    logic                   rd_req_valid_o;
    logic                   wr_req_valid_o;
    logic                   req_is_instr_o;
    logic [PADDR_WIDTH-1:0] req_address_o;
    logic [LINE_WIDTH-1:0]  wr_data_o;
    logic [SIZE_WIDTH-1:0]  req_access_size_o;
    logic                   mem_data_valid_i;
    logic [LINE_WIDTH-1:0]  mem_data_i;
    logic                   write_done_i;

    logic                   err_o;

    modport slave (
        input  i_req_valid_i, i_addr_i,
        output i_gnt_o, i_rsp_valid_o, i_rsp_data_o,
        input  d_req_valid_i, d_req_we_i, d_addr_i, d_size_i, d_wr_data_i,
        output d_gnt_o, d_rsp_valid_o, d_rsp_data_o, d_wr_done_o,
        output rd_req_valid_o, wr_req_valid_o, req_is_instr_o, req_address_o, wr_data_o,
        output req_access_size_o,
        input  mem_data_valid_i, mem_data_i, write_done_i,
        output err_o
    );

    modport master (
        output i_req_valid_i, i_addr_i,
        input  i_gnt_o, i_rsp_valid_o, i_rsp_data_o,
        output d_req_valid_i, d_req_we_i, d_addr_i, d_size_i, d_wr_data_i,
        input  d_gnt_o, d_rsp_valid_o, d_rsp_data_o, d_wr_done_o,
        input  rd_req_valid_o, wr_req_valid_o, req_is_instr_o, req_address_o, wr_data_o,
        input  req_access_size_o,
        output mem_data_valid_i, mem_data_i, write_done_i,
        input  err_o
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Shares the single unified memory port between the instruction-fetch and data paths.
// Owns one outstanding transaction: arbitrates only in IDLE, issues a registered request,
// remembers the owner and routes the read response (or write completion) back to it.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous reset, active-low
//   bus    - mem_req_arbiter_if.slave (fetch, data, memory and error signals)
// Configuration:
//   MEM_ARB_RR_EN defined   - round-robin tie break (path not granted last wins; first tie -> fetch)
//   MEM_ARB_RR_EN undefined - fixed priority, data wins ties
// Issued address/size/owner/write data hold their last value until the next grant.
module mem_req_arbiter #(
    parameter int unsigned PADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH  = 128,
    parameter int unsigned SIZE_WIDTH  = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mem_req_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RD_WAIT = 2'b01;
    localparam logic [1:0] ST_WR_WAIT = 2'b10;

    localparam logic [SIZE_WIDTH-1:0] SIZE_WORD = SIZE_WIDTH'(2'b10);

    logic [1:0]             state_q, state_d;
    logic                   i_gnt_q, i_gnt_d;
    logic                   d_gnt_q, d_gnt_d;
    logic                   i_rsp_valid_q, i_rsp_valid_d;
    logic [LINE_WIDTH-1:0]  i_rsp_data_q, i_rsp_data_d;
    logic                   d_rsp_valid_q, d_rsp_valid_d;
    logic [LINE_WIDTH-1:0]  d_rsp_data_q, d_rsp_data_d;
    logic                   d_wr_done_q, d_wr_done_d;
    logic                   rd_req_q, rd_req_d;
    logic                   wr_req_q, wr_req_d;
    logic                   is_instr_q, is_instr_d;
    logic [PADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic [SIZE_WIDTH-1:0]  size_q, size_d;
    logic                   owner_instr_q, owner_instr_d;
    logic                   err_q, err_d;
    logic                   pick_data, pick_fetch;
    logic                   stray_rd, stray_wr;
`ifdef MEM_ARB_RR_EN
    logic                   last_gnt_instr_q, last_gnt_instr_d;
`endif

    // Next-state, arbitration, response routing and error detection
    always_comb begin
        state_d       = state_q;
        i_gnt_d       = 1'b0;
        d_gnt_d       = 1'b0;
        i_rsp_valid_d = 1'b0;
        d_rsp_valid_d = 1'b0;
        d_wr_done_d   = 1'b0;
        rd_req_d      = 1'b0;
        wr_req_d      = 1'b0;
        i_rsp_data_d  = i_rsp_data_q;
        d_rsp_data_d  = d_rsp_data_q;
        is_instr_d    = is_instr_q;
        addr_d        = addr_q;
        wr_data_d     = wr_data_q;
        size_d        = size_q;
        owner_instr_d = owner_instr_q;
`ifdef MEM_ARB_RR_EN
        last_gnt_instr_d = last_gnt_instr_q;
`endif
        pick_data     = 1'b0;
        pick_fetch    = 1'b0;

        // A response is only legal in its own wait state and never both at once
        stray_rd = bus.mem_data_valid_i && ((state_q != ST_RD_WAIT) || bus.write_done_i);
        stray_wr = bus.write_done_i && ((state_q != ST_WR_WAIT) || bus.mem_data_valid_i);
        err_d    = err_q | stray_rd | stray_wr;

        case (state_q)
            ST_IDLE: begin
`ifdef MEM_ARB_RR_EN
                // On a tie, data wins only if fetch was granted last
                pick_data = bus.d_req_valid_i && (!bus.i_req_valid_i || last_gnt_instr_q);
`else
                pick_data = bus.d_req_valid_i;
`endif
                pick_fetch = bus.i_req_valid_i && !pick_data;

                if (pick_data) begin
                    d_gnt_d       = 1'b1;
                    owner_instr_d = 1'b0;
                    is_instr_d    = 1'b0;
                    addr_d        = bus.d_addr_i;
                    size_d        = bus.d_size_i;
                    if (bus.d_req_we_i) begin
                        wr_req_d  = 1'b1;
                        wr_data_d = bus.d_wr_data_i;
                        state_d   = ST_WR_WAIT;
                    end else begin
                        rd_req_d  = 1'b1;
                        state_d   = ST_RD_WAIT;
                    end
                end else if (pick_fetch) begin
                    i_gnt_d       = 1'b1;
                    owner_instr_d = 1'b1;
                    is_instr_d    = 1'b1;
                    addr_d        = bus.i_addr_i;
                    size_d        = SIZE_WORD;
                    rd_req_d      = 1'b1;
                    state_d       = ST_RD_WAIT;
                end
`ifdef MEM_ARB_RR_EN
                if (pick_data || pick_fetch) begin
                    last_gnt_instr_d = pick_fetch;
                end
`endif
            end
            ST_RD_WAIT: begin
                if (bus.mem_data_valid_i && !bus.write_done_i) begin
                    state_d = ST_IDLE;
                    if (owner_instr_q) begin
                        i_rsp_valid_d = 1'b1;
                        i_rsp_data_d  = bus.mem_data_i;
                    end else begin
                        d_rsp_valid_d = 1'b1;
                        d_rsp_data_d  = bus.mem_data_i;
                    end
                end
            end
            ST_WR_WAIT: begin
                if (bus.write_done_i && !bus.mem_data_valid_i) begin
                    state_d     = ST_IDLE;
                    d_wr_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= ST_IDLE;
            i_gnt_q       <= 1'b0;
            d_gnt_q       <= 1'b0;
            i_rsp_valid_q <= 1'b0;
            i_rsp_data_q  <= '0;
            d_rsp_valid_q <= 1'b0;
            d_rsp_data_q  <= '0;
            d_wr_done_q   <= 1'b0;
            rd_req_q      <= 1'b0;
            wr_req_q      <= 1'b0;
            is_instr_q    <= 1'b0;
            addr_q        <= '0;
            wr_data_q     <= '0;
            size_q        <= '0;
            owner_instr_q <= 1'b0;
            err_q         <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_gnt_instr_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            i_gnt_q       <= i_gnt_d;
            d_gnt_q       <= d_gnt_d;
            i_rsp_valid_q <= i_rsp_valid_d;
            i_rsp_data_q  <= i_rsp_data_d;
            d_rsp_valid_q <= d_rsp_valid_d;
            d_rsp_data_q  <= d_rsp_data_d;
            d_wr_done_q   <= d_wr_done_d;
            rd_req_q      <= rd_req_d;
            wr_req_q      <= wr_req_d;
            is_instr_q    <= is_instr_d;
            addr_q        <= addr_d;
            wr_data_q     <= wr_data_d;
            size_q        <= size_d;
            owner_instr_q <= owner_instr_d;
            err_q         <= err_d;
`ifdef MEM_ARB_RR_EN
            last_gnt_instr_q <= last_gnt_instr_d;
`endif
        end
    end

    assign bus.i_gnt_o           = i_gnt_q;
    assign bus.i_rsp_valid_o     = i_rsp_valid_q;
    assign bus.i_rsp_data_o      = i_rsp_data_q;
    assign bus.d_gnt_o           = d_gnt_q;
    assign bus.d_rsp_valid_o     = d_rsp_valid_q;
    assign bus.d_rsp_data_o      = d_rsp_data_q;
    assign bus.d_wr_done_o       = d_wr_done_q;
    assign bus.rd_req_valid_o    = rd_req_q;
    assign bus.wr_req_valid_o    = wr_req_q;
    assign bus.req_is_instr_o    = is_instr_q;
    assign bus.req_address_o     = addr_q;
    assign bus.wr_data_o         = wr_data_q;
    assign bus.req_access_size_o = size_q;
    assign bus.err_o             = err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_mem_req_arbiter;
    localparam int unsigned PADDR_WIDTH = 32;
    localparam int unsigned LINE_WIDTH  = 128;
    localparam int unsigned SIZE_WIDTH  = 2;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_i;
    int   checks = 0;
    int   errors = 0;

    mem_req_arbiter_if #(.PADDR_WIDTH(PADDR_WIDTH), .LINE_WIDTH(LINE_WIDTH), .SIZE_WIDTH(SIZE_WIDTH)) bus ();

    mem_req_arbiter #(.PADDR_WIDTH(PADDR_WIDTH), .LINE_WIDTH(LINE_WIDTH), .SIZE_WIDTH(SIZE_WIDTH)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    // flag order: i_gnt d_gnt rd wr instr i_rsp d_rsp d_done err
    typedef struct {
        logic [4:0]   ctl;   // i_req d_req d_we mem_valid wr_done
        logic [31:0]  ia;
        logic [31:0]  da;
        logic [127:0] wd;
        logic [127:0] md;
        logic [8:0]   ef;
        logic [31:0]  ea;
        logic [1:0]   es;
        bit           hold;  // transaction in flight: address/size/owner must be held
    } vec_t;

    vec_t vt[17];

    // reference model state (transaction level)
    bit           m_out;
    bit           m_owner_i;
    bit           m_we;
    bit           m_last_i;
    bit           m_err;
    logic [31:0]  m_addr;
    logic [1:0]   m_size;
    int           resp_timer;
    bit           resp_wr;
    bit           auto_mem;
    byte          glog[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] flags();
        return {bus.i_gnt_o, bus.d_gnt_o, bus.rd_req_valid_o, bus.wr_req_valid_o, bus.req_is_instr_o,
                bus.i_rsp_valid_o, bus.d_rsp_valid_o, bus.d_wr_done_o, bus.err_o};
    endfunction

    function automatic vec_t mkv(input logic [4:0] ctl, input logic [31:0] ia, input logic [31:0] da,
                                 input logic [127:0] wd, input logic [127:0] md, input logic [8:0] ef,
                                 input logic [31:0] ea, input logic [1:0] es, input bit hold);
        vec_t v;
        v.ctl = ctl; v.ia = ia; v.da = da; v.wd = wd; v.md = md;
        v.ef = ef; v.ea = ea; v.es = es; v.hold = hold;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_req_valid_i    = 1'b0;
        bus.i_addr_i         = '0;
        bus.d_req_valid_i    = 1'b0;
        bus.d_req_we_i       = 1'b0;
        bus.d_addr_i         = '0;
        bus.d_size_i         = '0;
        bus.d_wr_data_i      = '0;
        bus.mem_data_valid_i = 1'b0;
        bus.mem_data_i       = '0;
        bus.write_done_i     = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        clear_inputs();
        repeat (2) tick();
        rst_i      = 1'b1;
        m_out      = 1'b0;
        m_last_i   = 1'b0;
        m_err      = 1'b0;
        m_addr     = '0;
        m_size     = '0;
        resp_timer = -1;
    endtask

    // One clock of the model-checked environment: compare, then act as requesters and memory
    task automatic step();
        logic [8:0] ef;
        bit gi, gd;
        bit rsp;
        logic [127:0] rdata;
        tick();
        ef = '0; gi = 1'b0; gd = 1'b0; rsp = 1'b0; rdata = '0;
        m_err = m_err
              | (bus.mem_data_valid_i && !(m_out && !m_we))
              | (bus.write_done_i && !(m_out && m_we))
              | (bus.mem_data_valid_i && bus.write_done_i);
        if (m_out && !m_we && bus.mem_data_valid_i && !bus.write_done_i) begin
            rsp = 1'b1;
            rdata = bus.mem_data_i;
            if (m_owner_i) ef[3] = 1'b1; else ef[2] = 1'b1;
            m_out = 1'b0;
        end else if (m_out && m_we && bus.write_done_i && !bus.mem_data_valid_i) begin
            ef[1] = 1'b1;
            m_out = 1'b0;
        end else if (!m_out && (bus.i_req_valid_i || bus.d_req_valid_i)) begin
            if (bus.i_req_valid_i && bus.d_req_valid_i) gd = RR ? m_last_i : 1'b1;
            else gd = bus.d_req_valid_i;
            gi = !gd;
            m_out     = 1'b1;
            m_owner_i = gi;
            m_we      = gd && bus.d_req_we_i;
            m_addr    = gi ? bus.i_addr_i : bus.d_addr_i;
            m_size    = gi ? 2'b10 : bus.d_size_i;
            m_last_i  = gi;
            ef[8] = gi; ef[7] = gd; ef[6] = !m_we; ef[5] = m_we;
        end
        ef[0] = m_err;
        chk("model flags", flags() & 9'h1EF, ef);
        if (m_out) begin
            chk("model owner", 128'(bus.req_is_instr_o), 128'(m_owner_i));
            chk("model addr", 128'(bus.req_address_o), 128'(m_addr));
            chk("model size", 128'(bus.req_access_size_o), 128'(m_size));
        end
        if ((gd && m_we)) chk("model wdata", bus.wr_data_o, bus.d_wr_data_i);
        if (rsp && ef[3]) chk("model i_rsp data", bus.i_rsp_data_o, rdata);
        if (rsp && ef[2]) chk("model d_rsp data", bus.d_rsp_data_o, rdata);
        // requesters drop valid once granted
        if (bus.i_gnt_o) begin bus.i_req_valid_i = 1'b0; glog.push_back("i"); end
        if (bus.d_gnt_o) begin bus.d_req_valid_i = 1'b0; glog.push_back("d"); end
        // memory: respond 0..3 cycles after a request pulse
        if (auto_mem) begin
            bus.mem_data_valid_i = 1'b0;
            bus.write_done_i     = 1'b0;
            if (bus.rd_req_valid_o || bus.wr_req_valid_o) begin
                resp_timer = int'($urandom_range(0, 3));
                resp_wr    = bus.wr_req_valid_o;
            end
            if (resp_timer == 0) begin
                if (resp_wr) bus.write_done_i = 1'b1;
                else begin
                    bus.mem_data_valid_i = 1'b1;
                    bus.mem_data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
                end
                resp_timer = -1;
            end else if (resp_timer > 0) begin
                resp_timer--;
            end
        end
    endtask

    initial begin
        logic [8:0] mask;
        int         d_done_cnt;
        int         target;
        int         cyc;

        auto_mem   = 1'b0;
        resp_timer = -1;
        resp_wr    = 1'b0;
        rst_i      = 1'b0;
        clear_inputs();

        // --- reset state, before and after clock edges ---
        #2;
        chk("reset flags async", flags(), 9'b0);
        repeat (2) tick();
        chk("reset flags", flags(), 9'b0);
        chk("reset addr", bus.req_address_o, 128'h0);
        chk("reset wdata", bus.wr_data_o, 128'h0);
        chk("reset size", bus.req_access_size_o, 128'h0);
        chk("reset i_rsp data", bus.i_rsp_data_o, 128'h0);
        chk("reset d_rsp data", bus.d_rsp_data_o, 128'h0);
        do_reset();

        // --- directed vector table ---
        vt[0]  = mkv(5'b10000, 32'h1000, 0, 0, 0, 9'b101010000, 32'h1000, 2'b10, 1);
        vt[1]  = mkv(5'b00000, 0, 0, 0, 0, 9'b000010000, 32'h1000, 2'b10, 1);
        vt[2]  = mkv(5'b00000, 0, 0, 0, 0, 9'b000010000, 32'h1000, 2'b10, 1);
        vt[3]  = mkv(5'b00010, 0, 0, 0, 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff, 9'b000001000, 0, 0, 0);
        vt[4]  = mkv(5'b00000, 0, 0, 0, 0, 9'b000000000, 0, 0, 0);
        vt[5]  = mkv(5'b01100, 0, 32'h0040, 128'hDEADBEEF, 0, 9'b010100000, 32'h0040, 2'b01, 1);
        vt[6]  = mkv(5'b00000, 0, 0, 0, 0, 9'b000000000, 32'h0040, 2'b01, 1);
        vt[7]  = mkv(5'b00001, 0, 0, 0, 0, 9'b000000010, 0, 0, 0);
        vt[8]  = mkv(5'b00000, 0, 0, 0, 0, 9'b000000000, 0, 0, 0);
        vt[9]  = mkv(5'b01000, 0, 32'h2000, 0, 0, 9'b011000000, 32'h2000, 2'b01, 1);
        vt[10] = mkv(5'b00010, 0, 0, 0, 128'hcafe_f00d_0000_0001, 9'b000000100, 0, 0, 0);
        vt[11] = mkv(5'b00010, 0, 0, 0, 128'h5555, 9'b000000001, 0, 0, 0);
        vt[12] = mkv(5'b00000, 0, 0, 0, 0, 9'b000000001, 0, 0, 0);
        vt[13] = mkv(5'b00001, 0, 0, 0, 0, 9'b000000001, 0, 0, 0);
        vt[14] = mkv(5'b10000, 32'h7000, 0, 0, 0, 9'b101010001, 32'h7000, 2'b10, 1);
        vt[15] = mkv(5'b00011, 0, 0, 0, 128'h6666, 9'b000010001, 32'h7000, 2'b10, 1);
        vt[16] = mkv(5'b00010, 0, 0, 0, 128'h7777_8888, 9'b000001001, 0, 0, 0);

        for (int k = 0; k < 17; k++) begin
            bus.i_req_valid_i    = vt[k].ctl[4];
            bus.d_req_valid_i    = vt[k].ctl[3];
            bus.d_req_we_i       = vt[k].ctl[2];
            bus.mem_data_valid_i = vt[k].ctl[1];
            bus.write_done_i     = vt[k].ctl[0];
            bus.i_addr_i         = vt[k].ia;
            bus.d_addr_i         = vt[k].da;
            bus.d_size_i         = 2'b01;
            bus.d_wr_data_i      = vt[k].wd;
            bus.mem_data_i       = vt[k].md;
            tick();
            mask = vt[k].hold ? 9'h1FF : 9'h1EF;
            chk($sformatf("vec%0d flags", k), flags() & mask, vt[k].ef & mask);
            if (vt[k].hold) begin
                chk($sformatf("vec%0d addr", k), 128'(bus.req_address_o), 128'(vt[k].ea));
                chk($sformatf("vec%0d size", k), 128'(bus.req_access_size_o), 128'(vt[k].es));
            end
            if (vt[k].ef[5]) chk($sformatf("vec%0d wdata", k), bus.wr_data_o, vt[k].wd);
            if (vt[k].ef[3]) chk($sformatf("vec%0d i_rsp data", k), bus.i_rsp_data_o, vt[k].md);
            if (vt[k].ef[2]) chk($sformatf("vec%0d d_rsp data", k), bus.d_rsp_data_o, vt[k].md);
        end
        clear_inputs();

        // --- asynchronous reset clears the sticky error ---
        #2 rst_i = 1'b0;
        #1;
        chk("err cleared by reset", flags(), 9'b0);
        do_reset();

        // --- simultaneous requests: tie winner and serialisation ---
        auto_mem = 1'b1;
        glog.delete();
        bus.i_req_valid_i = 1'b1; bus.i_addr_i = 32'h3000;
        bus.d_req_valid_i = 1'b1; bus.d_req_we_i = 1'b0; bus.d_addr_i = 32'h4000; bus.d_size_i = 2'b11;
        cyc = 0;
        while (glog.size() < 2 && cyc < 60) begin step(); cyc++; end
        chk("tie grant count", 128'(glog.size()), 128'd2);
        if (glog.size() == 2) begin
            chk("tie first grant", 128'(glog[0]), RR ? 128'("i") : 128'("d"));
            chk("tie second grant", 128'(glog[1]), RR ? 128'("d") : 128'("i"));
        end
        repeat (8) step();
        auto_mem = 1'b0;
        clear_inputs();

        // --- reset during RD_WAIT, then a late stray response ---
        do_reset();
        bus.i_req_valid_i = 1'b1; bus.i_addr_i = 32'h5000;
        tick();
        chk("rw gnt", flags(), 9'b101010000);
        bus.i_req_valid_i = 1'b0;
        tick();
        #2 rst_i = 1'b0;
        #1;
        chk("rw reset flags", flags(), 9'b0);
        chk("rw reset addr", bus.req_address_o, 128'h0);
        chk("rw reset size", bus.req_access_size_o, 128'h0);
        #1 rst_i = 1'b1;
        tick();
        bus.mem_data_valid_i = 1'b1; bus.mem_data_i = 128'h9999;
        tick();
        chk("rw late rsp err", flags(), 9'b000000001);
        do_reset();
        bus.i_req_valid_i = 1'b1; bus.i_addr_i = 32'h6000;
        tick();
        chk("rw refetch gnt", flags(), 9'b101010000);
        chk("rw refetch addr", 128'(bus.req_address_o), 128'h6000);
        bus.i_req_valid_i = 1'b0;
        bus.mem_data_valid_i = 1'b1; bus.mem_data_i = 128'hABCD_0123;
        tick();
        chk("rw refetch rsp", flags() & 9'h1EF, 9'b000001000);
        chk("rw refetch data", bus.i_rsp_data_o, 128'hABCD_0123);
        clear_inputs();

        // --- back-to-back data loads with fetch pending ---
        do_reset();
        auto_mem = 1'b1;
        glog.delete();
        d_done_cnt = 0;
        target = RR ? 20 : 11;
        bus.d_req_valid_i = 1'b1; bus.d_req_we_i = 1'b0; bus.d_addr_i = 32'h0000_0100; bus.d_size_i = 2'b10;
        step();
        bus.i_req_valid_i = 1'b1; bus.i_addr_i = 32'h8000;
        cyc = 0;
        while (glog.size() < target && cyc < 600) begin
            if (bus.d_gnt_o) d_done_cnt++;
            if (bus.d_gnt_o && d_done_cnt < 10) begin
                bus.d_req_valid_i = 1'b1;
                bus.d_addr_i = 32'h100 * (d_done_cnt + 1);
            end
            if (bus.i_gnt_o && d_done_cnt < 10) begin
                bus.i_req_valid_i = 1'b1;
                bus.i_addr_i = bus.i_addr_i + 32'h10;
            end
            step();
            cyc++;
        end
        chk("b2b grant count", 128'(glog.size()), 128'(target));
        for (int k = 0; k < glog.size() && k < target; k++) begin
            byte e;
            if (RR) e = (k % 2 == 0) ? "d" : "i";
            else e = (k < 10) ? "d" : "i";
            chk($sformatf("b2b grant %0d", k), 128'(glog[k]), 128'(e));
        end
        repeat (8) step();
        clear_inputs();

        // --- randomized traffic against the reference model ---
        do_reset();
        auto_mem = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            step();
            if (!bus.i_req_valid_i && $urandom_range(0, 3) == 0) begin
                bus.i_req_valid_i = 1'b1;
                bus.i_addr_i = $urandom() & 32'hFFFF_FFF0;
            end else if (bus.i_req_valid_i && $urandom_range(0, 15) == 0) begin
                bus.i_req_valid_i = 1'b0;
            end
            if (!bus.d_req_valid_i && $urandom_range(0, 2) == 0) begin
                bus.d_req_valid_i = 1'b1;
                bus.d_req_we_i    = 1'($urandom_range(0, 1));
                bus.d_addr_i      = $urandom();
                bus.d_size_i      = 2'($urandom_range(0, 3));
                bus.d_wr_data_i   = {$urandom(), $urandom(), $urandom(), $urandom()};
            end else if (bus.d_req_valid_i && $urandom_range(0, 15) == 0) begin
                bus.d_req_valid_i = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
